// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Op codes, FSM states and small op-class helpers.
package hilo_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_ACC  = ST_ACC,
    S_DIV  = ST_DIV,
    S_DONE = ST_DONE
  } mdu_state_t;

  function automatic logic op_signed(mdu_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic op_is_div(mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic op_is_acc(mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(mdu_op_t op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic [31:0] mag(
    logic [31:0] v,
    logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// EXE <-> MDU bundle: issue, operands, flush, stall and result.
interface hilo_mdu_ctrl_if;
  import hilo_mdu_ctrl_pkg::*;

  logic        op_valid;
  mdu_op_t     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        stall_req;
  logic        finish;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  modport master (
    output op_valid, op, src_a, src_b,
    output hi_in, lo_in, flush,
    input  stall_req, finish, res_hi, res_lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b,
    input  hi_in, lo_in, flush,
    output stall_req, finish, res_hi, res_lo
  );

endinterface

// File: rtl/hilo_mdu_ctrl_div_radix2_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes.
// q/r present the state after the current step.
module div_radix2_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [63:0] rq;
  logic [31:0] d;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        ge;
  logic [63:0] nxt;

  // shifted remainder needs 33 bits: 2*r + bit may exceed 2^32
  assign rem_sh = rq[63:31];
  assign trial  = rem_sh - {1'b0, d};
  assign ge     = !trial[32];

  always_comb begin
    nxt = {rem_sh[31:0], rq[30:0], ge};
    if (ge)
      nxt[63:32] = trial[31:0];
  end

  assign q = nxt[31:0];
  assign r = nxt[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      rq <= '0;
      d  <= '0;
    end else if (start) begin
      rq <= {32'b0, dividend};
      d  <= divisor;
    end else if (step) begin
      rq <= nxt;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Multi-cycle MULT/DIV/MADD/MSUB sequencer for the HI/LO pair.
// Stalls IF..EXE while busy; flush or reset aborts to IDLE.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_ITER = 32
) (
  input logic                 clk,
  input logic                 rst,
  hilo_mdu_ctrl_if.slave      mdu
);

  localparam logic [5:0] LAST = 6'(DIV_ITER - 1);

  mdu_state_t  state;
  mdu_op_t     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic [63:0] prod_q;
  logic [5:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic        accept;
  logic        sgn;
  logic [63:0] prod;
  logic [63:0] acc_res;
  logic [31:0] dq;
  logic [31:0] dr;
  logic [63:0] div_res;

  assign accept = (state == S_IDLE) && mdu.op_valid
                  && !mdu.flush;
  assign sgn    = op_signed(op_q);

  assign prod = sgn
    ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q}
    : {32'b0, a_q} * {32'b0, b_q};

  assign acc_res = op_is_sub(op_q) ? acc_q - prod_q
                                   : acc_q + prod_q;

  div_radix2_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && op_is_div(mdu.op)),
    .step     ((state == S_DIV) && !mdu.flush),
    .dividend (mag(mdu.src_a, op_signed(mdu.op))),
    .divisor  (mag(mdu.src_b, op_signed(mdu.op))),
    .q        (dq),
    .r        (dr)
  );

  // zero divisor bypasses the sign fix: HI=dividend, LO=all ones
  always_comb begin
    div_res = {dr, dq};
    if (sgn && (a_q[31] ^ b_q[31]))
      div_res[31:0] = -dq;
    if (sgn && a_q[31])
      div_res[63:32] = -dr;
    if (b_q == '0)
      div_res = {a_q, 32'hFFFF_FFFF};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (mdu.flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (mdu.op_valid) begin
          op_q  <= mdu.op;
          a_q   <= mdu.src_a;
          b_q   <= mdu.src_b;
          acc_q <= {mdu.hi_in, mdu.lo_in};
          cnt   <= '0;
          unique case (1'b1)
            op_is_div(mdu.op): state <= S_DIV;
            default:           state <= S_MUL;
          endcase
        end
        S_MUL: begin
          prod_q <= prod;
          if (op_is_acc(op_q)) begin
            state <= S_ACC;
          end else begin
            state             <= S_DONE;
            {res_hi, res_lo}  <= prod;
          end
        end
        S_ACC: begin
          state            <= S_DONE;
          {res_hi, res_lo} <= acc_res;
        end
        S_DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            state            <= S_DONE;
            {res_hi, res_lo} <= div_res;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mdu.stall_req = accept || (state == S_MUL)
                      || (state == S_ACC)
                      || (state == S_DIV);
  assign mdu.finish    = (state == S_DONE) && !mdu.flush;
  assign mdu.res_hi    = res_hi;
  assign mdu.res_lo    = res_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: expected results queued at
// issue, popped and compared when finish strobes.
module tb_hilo_mdu_ctrl;
  import hilo_mdu_ctrl_pkg::*;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  hilo_mdu_ctrl_if mdu();

  hilo_mdu_ctrl #(.DIV_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(mdu_op_t op);
    if (op inside {OP_DIV, OP_DIVU}) return 33;
    if (op[2]) return 3;
    return 2;
  endfunction

  function automatic logic [63:0] model(mdu_op_t op,
    logic [31:0] a, logic [31:0] b,
    logic [31:0] hi, logic [31:0] lo);
    longint sp;
    logic [63:0] up;
    int sa, sbv;
    sa  = $signed(a);
    sbv = $signed(b);
    sp  = longint'(sa) * longint'(sbv);
    up  = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return {hi, lo} + sp;
      OP_MADDU: return {hi, lo} + up;
      OP_MSUB:  return {hi, lo} - sp;
      OP_MSUBU: return {hi, lo} - up;
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
    endcase
  endfunction

  task automatic drive(mdu_op_t op, logic [31:0] a,
    logic [31:0] b, logic [31:0] hi, logic [31:0] lo);
    mdu.op_valid = 1;
    mdu.op       = op;
    mdu.src_a    = a;
    mdu.src_b    = b;
    mdu.hi_in    = hi;
    mdu.lo_in    = lo;
  endtask

  task automatic issue(string tag, mdu_op_t op,
    logic [31:0] a, logic [31:0] b,
    logic [31:0] hi, logic [31:0] lo,
    logic [63:0] exp);
    int n;
    @(posedge clk); #1;
    drive(op, a, b, hi, lo);
    sb.push_back('{res: exp, cyc: cyc + lat(op), tag: tag});
    #1 chk({tag, "_stall_on"}, 64'(mdu.stall_req), 64'd1);
    n = 0;
    while (mdu.stall_req && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    mdu.op_valid = 0;
    chk({tag, "_stall_len"}, 64'(n), 64'(lat(op)));
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (mdu.finish) begin
      if (sb.size() == 0) begin
        chk("spurious_finish", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, 64'(mdu.res_hi), 64'(e.res[63:32]));
        chk({e.tag, "_lo"}, 64'(mdu.res_lo), 64'(e.res[31:0]));
        chk({e.tag, "_cyc"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    mdu_op_t     rop;
    logic [31:0] ra, rb, rh, rl;
    int          t0;
    mdu.op_valid = 0;
    mdu.op       = OP_MULT;
    mdu.src_a    = 0;
    mdu.src_b    = 0;
    mdu.hi_in    = 0;
    mdu.lo_in    = 0;
    mdu.flush    = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_hi", 64'(mdu.res_hi), 64'd0);
    chk("rst_lo", 64'(mdu.res_lo), 64'd0);
    chk("rst_fin", 64'(mdu.finish), 64'd0);
    chk("rst_stall", 64'(mdu.stall_req), 64'd0);

    issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFA);
    issue("maddu", OP_MADDU, 32'd1, 32'd1, 32'h0,
          32'hFFFF_FFFF, 64'h0000_0001_0000_0000);
    issue("msub", OP_MSUB, 32'd2, 32'd3, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFA);
    issue("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFD);
    issue("divu_z", OP_DIVU, 32'd100, 32'd0, 0, 0,
          64'h0000_0064_FFFF_FFFF);
    issue("div_z", OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, 0,
          64'hFFFF_FFF0_FFFF_FFFF);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          0, 0, 64'h0000_0000_8000_0000);

    // DIV flushed at T+10; nothing is queued for it
    @(posedge clk); #1;
    t0 = cyc;
    drive(OP_DIV, 32'd1000, 32'd7, 0, 0);
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    mdu.flush    = 1;
    mdu.op_valid = 0;
    @(posedge clk); #1;
    mdu.flush = 0;
    chk("flush_stall", 64'(mdu.stall_req), 64'd0);
    chk("flush_fin", 64'(mdu.finish), 64'd0);
    issue("mult_after_flush", OP_MULT, 32'd7,
          32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9);

    // flush during DONE suppresses finish
    @(posedge clk); #1;
    drive(OP_MULTU, 32'd5, 32'd5, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mdu.flush    = 1;
    mdu.op_valid = 0;
    @(posedge clk); #1;
    mdu.flush = 0;
    chk("done_flush_hold", 64'(mdu.res_hi), 64'd0);

    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: rop = OP_MULTU;
        1: rop = OP_DIVU;
        2: rop = OP_DIV;
        default: rop = OP_MSUBU;
      endcase
      ra = $urandom;
      rb = $urandom;
      rh = $urandom;
      rl = $urandom;
      if (rb == 0) rb = 32'd3;
      issue($sformatf("rnd%0d", i), rop, ra, rb, rh, rl,
            model(rop, ra, rb, rh, rl));
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

Multi-cycle multiply/divide sequencer that computes the HI/LO results and the completion strobe for the HI/LO register pair in EXE. It accepts one MDU instruction at a time and handles signed and unsigned forms. MADD/MSUB variants accumulate onto the HI/LO value sampled at issue. While an operation is in flight it stalls the pipeline, and it aborts cleanly on flush.

## Interface
Parameters:
- `DIV_ITER`, default 32: quotient bits produced, one per cycle.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `op_valid`  in  1  EXE holds an MDU instruction; held high while `stall_req` is high
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- `src_a`, `src_b`  in  32  rs, rt operands
- `hi_in`, `lo_in`  in  32  current HI/LO, used only by the accumulate ops
- `flush`  in  1  exception/ERET flush of EXE
- `stall_req`  out  1  freeze IF..EXE
- `finish`  out  1  one-cycle strobe; the HI/LO pair writes `res_hi`/`res_lo` on this strobe
- `res_hi`, `res_lo`  out  32  result

## Operation
- FSM states: IDLE, MUL, ACC, DIV, DONE.
- **IDLE**
  - On `op_valid && !flush`: latch the operands, `hi_in`/`lo_in` and `op`.
  - op 0/1 go to MUL, op 4–7 go to MUL, op 2/3 go to DIV.
- **MUL**
  - Register the 64-bit product: signed for op 0/4/6, unsigned otherwise.
  - Next state: DONE for op 0/1, ACC for op 4–7.
- **ACC**
  - Compute {hi,lo} ± product, modulo 2^64. Add for op 4/5, subtract for op 6/7.
  - Next state: DONE.
- **DIV**
  - Restoring radix-2 iteration on absolute values, one quotient bit per cycle.
  - A 6-bit counter runs 0..DIV_ITER-1; the final iteration goes to DONE.
- **DONE**
  - Apply the sign fix for DIV: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Drive `finish`=1 and present the result: HI = remainder, LO = quotient for divide.
  - Next state: IDLE.
- `stall_req` = (IDLE && `op_valid` && !`flush`) || state ∈ {MUL, ACC, DIV}.
  - It is low in DONE, so the issuing instruction leaves EXE in the finish cycle.
  - `op_valid` is ignored in DONE.
- Divide by zero: full normal latency; result LO = 0xFFFFFFFF, HI = `src_a`, for both signed and unsigned divide.
- 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0.
- Flush in any state: go to IDLE on the next edge, no `finish`, results discarded. Flush in the DONE cycle suppresses `finish`.
- Reset values: state IDLE, `finish` 0, `stall_req` 0 (when `op_valid`=0), `res_hi`/`res_lo` 0. Reset mid-operation behaves like flush.

## Timing
- Issue cycle = T (IDLE, op accepted).
- MULT/MULTU: `finish` at T+2.
- MADD-family: `finish` at T+3.
- DIV/DIVU: DIV during T+1..T+32, `finish` at T+33.
- `res_hi`/`res_lo` are registered and valid only while `finish`=1; they hold their value otherwise.
- No back-to-back overlap: the next op can be accepted at the earliest in the cycle after DONE.

## Structure
- Shared package entries: the `mdu_op_t` enum (3-bit op codes) and the `mdu_state_t` enum.
- Sub-module `div_radix2_iter`:
  - Holds the 64-bit partial remainder/quotient register, `start`, `step`, and `q`/`r` outputs.
  - Performs absolute-value input only; the controller does the sign fix.
- Multiplier: a single-cycle `*` in MUL; the registered product feeds ACC/DONE.

## Test plan
- MULT 0xFFFFFFFE × 3, issued at T → `finish` at T+2, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `stall_req` high T..T+1, low at T+2.
- MADDU, HI/LO = 0x00000000_FFFFFFFF, 1 × 1 → `finish` at T+3, HI = 1, LO = 0.
- MSUB, HI/LO = 0, 2 × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- DIV −7 / 2 → `finish` at T+33, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100, `finish` at T+33.
- DIV with `flush` at T+10 → IDLE at T+11, no `finish`, `stall_req` low. A MULT issued at T+12 then completes normally at T+14.
